css_mcu0_dmi_arbiter: RTL and testbench
=======================================

Name: css_mcu0_dmi_arbiter

Overview:
- Shares the single MCU0 debug-module DMI register port between two requesters:
  - the JTAG DMI path, whose strobes have already been synchronised into the core clock domain;
  - a software/mailbox debug requester driven from the MCI side.
- Serialises commands, arbitrates round-robin, sequences the DM access and returns read data to the owning requester.
- Sits between the TAP-side DMI wrapper and the debug module.

Parameters:
- AWIDTH, 7, DMI address width.
- NUM_REQ, 2, number of requesters. Fixed at 2; requester 0 = JTAG, 1 = SW.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_ready  output  NUM_REQ  per-requester command accept
- req_write  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*AWIDTH  packed command addresses
- req_wdata  input  NUM_REQ*32  packed write data
- rsp_valid  output  NUM_REQ  one-cycle response pulse
- rsp_rdata  output  32  response data, shared, qualified by rsp_valid
- dmi_reg_en  output  1  DM access strobe
- dmi_reg_wr_en  output  1  DM write qualifier
- dmi_reg_addr  output  AWIDTH  DM register address
- dmi_reg_wdata  output  32  DM write data
- dmi_reg_rdata  input  32  DM read data, valid the cycle after dmi_reg_en
- busy  output  1  transaction in flight
- last_grant  output  1  index of the most recently granted requester
- req_lock  input  NUM_REQ  bus-hold request; present only with the optional feature

Behaviour:
- Reset: synchronous, active-high; `rst` sampled on the clk edge.
  - FSM to IDLE.
  - All outputs 0, including rsp_rdata = 0 and last_grant = 0.
  - Round-robin pointer favours requester 0.
- FSM states: IDLE, CMD, CAPT, RSP.
- IDLE:
  - If any req_valid is set, grant by round-robin: the requester other than last_grant wins a tie.
  - req_ready[g] = 1 combinationally, for the granted index only, only in IDLE.
  - On the handshake (valid & ready), latch write/addr/wdata/grant index and go to CMD.
  - With no request, stay in IDLE.
- CMD: dmi_reg_en = 1 for exactly one cycle; dmi_reg_wr_en = latched write; addr/wdata driven from latches. Next state CAPT.
- CAPT:
  - Read: capture dmi_reg_rdata into rsp_rdata.
  - Write: load 0 into rsp_rdata.
  - Next state RSP.
- RSP: rsp_valid[g] = 1 for one cycle and last_grant updates to g. Next state IDLE.
- Latency and throughput:
  - Handshake at cycle N → dmi_reg_en at N+1 → rsp_valid at N+3.
  - Next accept earliest at N+4, giving maximum throughput of one command per 4 cycles.
- busy = 1 in CMD, CAPT and RSP.
- dmi_reg_addr/wdata hold their latched values outside CMD; only dmi_reg_en qualifies them.
- Boundary cases:
  - Simultaneous valids: alternate strictly. With both held continuously, grants go 0,1,0,1…
  - A requester dropping req_valid without a handshake is legal and has no effect.
  - Reset in any state aborts the transaction: no rsp_valid is issued, and any DM side effect already strobed stands.
  - rsp_valid is never asserted to the non-owning requester.
  - A response cannot be back-pressured; requesters must sink it.

Optional Feature:
- Macro: CSS_MCU0_DMI_ARB_LOCK_EN.
- Defined:
  - req_lock is present.
  - If the owner has req_lock = 1 in RSP, the arbiter enters a locked mode in which IDLE grants only that owner; the other requester's req_ready stays 0.
  - The lock releases in IDLE when the owner's req_lock = 0.
  - The lock clears on reset.
- Undefined: req_lock port absent; pure round-robin.

Decomposition:
- Package css_mcu0_dmi_arb_pkg holds:
  - dmi_arb_state_e enum (IDLE=2'd0, CMD=2'd1, CAPT=2'd2, RSP=2'd3);
  - requester index constants REQ_JTAG=0, REQ_SW=1;
  - a packed dmi_cmd_t struct {write, addr, wdata}.
- One sub-module: css_mcu0_dmi_rr_arb, a 2-way round-robin grant with pointer update and the lock override.

Test Plan:
- Single read: SW reads addr 0x11, DM returns 0x0000_0C82 → dmi_reg_en pulse at N+1 with wr_en=0 and addr=0x11; rsp_valid[1] at N+3 with rsp_rdata=0x0000_0C82.
- Single write: JTAG writes 0x10 = 0x8000_0001 → one dmi_reg_en cycle with wr_en=1 and wdata=0x8000_0001; rsp_valid[0] at N+3 with rsp_rdata=0.
- Contention: both valid from reset for 4 commands each → grant order 0,1,0,1,0,1,0,1; no overlap; exactly 8 dmi_reg_en pulses, 4 cycles apart.
- Reset mid-operation: assert rst in CAPT → next cycle all outputs 0, no rsp_valid; a subsequent SW read completes normally.
- Lock (macro on): JTAG holds req_lock across 3 reads while SW is valid → 3 JTAG grants back-to-back; SW granted only after lock drops.
- Idle stability: no valids for 100 cycles → dmi_reg_en, busy and rsp_valid all stay 0.

Source files
------------

// File: rtl/css_mcu0_dmi_arb_pkg.sv
// Shared types for the MCU0 DMI arbiter: FSM states, requester indices and latched command payload.
package css_mcu0_dmi_arb_pkg;

  localparam int unsigned DMI_AWIDTH = 7;
  localparam int unsigned DMI_DWIDTH = 32;

  localparam logic REQ_JTAG = 1'b0;
  localparam logic REQ_SW   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    CAPT = 2'd2,
    RSP  = 2'd3
  } dmi_arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [DMI_AWIDTH-1:0] addr;
    logic [DMI_DWIDTH-1:0] wdata;
  } dmi_cmd_t;

  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/css_mcu0_dmi_rr_arb.sv
// Two-way round-robin grant with pointer update on response; optional owner lock
// under CSS_MCU0_DMI_ARB_LOCK_EN.
module css_mcu0_dmi_rr_arb
  import css_mcu0_dmi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  input  logic [1:0] i_lock,
  input  logic       i_idle,
`endif
  input  logic       i_update,
  input  logic       i_owner,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);

  // Requester that wins a tie; the one not most recently served.
  logic r_ptr;

`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  logic r_lock;
  logic r_lock_idx;
  logic w_lock_on;

  assign w_lock_on = r_lock & i_lock[r_lock_idx];
`endif

  always_comb begin
    o_gnt_valid_c = |i_valid;
    o_gnt_idx_c   = REQ_JTAG;
    if (&i_valid) begin
      o_gnt_idx_c = r_ptr;
    end else begin
      o_gnt_idx_c = i_valid[REQ_JTAG] ? REQ_JTAG : REQ_SW;
    end
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    // A held lock restricts the grant to the lock owner only.
    if (w_lock_on) begin
      o_gnt_valid_c = i_valid[r_lock_idx];
      o_gnt_idx_c   = r_lock_idx;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= REQ_JTAG;
    end else if (i_update) begin
      r_ptr <= ~i_owner;
    end
  end

`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_idx <= REQ_JTAG;
    end else if (i_update) begin
      r_lock     <= i_lock[i_owner];
      r_lock_idx <= i_owner;
    end else if (i_idle && r_lock && !i_lock[r_lock_idx]) begin
      r_lock <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/css_mcu0_dmi_arbiter.sv
// Shares the MCU0 DM register port between the JTAG DMI path and the SW debug requester.
// Optional owner lock (req_lock) is built when CSS_MCU0_DMI_ARB_LOCK_EN is defined.
module css_mcu0_dmi_arbiter
  import css_mcu0_dmi_arb_pkg::*;
#(
  parameter int unsigned AWIDTH  = DMI_AWIDTH,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      dmi_reg_en,
  output logic                      dmi_reg_wr_en,
  output logic [AWIDTH-1:0]         dmi_reg_addr,
  output logic [31:0]               dmi_reg_wdata,
  input  logic [31:0]               dmi_reg_rdata,
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic                      busy,
  output logic                      last_grant
);

  dmi_arb_state_e r_state;
  dmi_arb_state_e w_state_nxt;
  dmi_cmd_t       r_cmd;
  dmi_cmd_t       w_cmd;
  logic           r_owner;
  logic [31:0]    r_rsp_rdata;
  logic           r_last_grant;
  logic           w_gnt_valid;
  logic           w_gnt_idx;
  logic           w_hs;
  logic           w_rsp;

  assign w_rsp = (r_state == RSP);

`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  logic w_idle;
  assign w_idle = (r_state == IDLE);
`endif

  css_mcu0_dmi_rr_arb u_rr_arb (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (req_valid),
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    .i_lock        (req_lock),
    .i_idle        (w_idle),
`endif
    .i_update      (w_rsp),
    .i_owner       (r_owner),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept strobe and the command selected for latching.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_hs        = 1'b0;
    w_cmd.write = w_gnt_idx ? req_write[1] : req_write[0];
    w_cmd.addr  = DMI_AWIDTH'(w_gnt_idx ? req_addr[2*AWIDTH-1:AWIDTH] : req_addr[AWIDTH-1:0]);
    w_cmd.wdata = w_gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
    case (r_state)
      IDLE: begin
        if (w_gnt_valid && !rst) begin
          req_ready[w_gnt_idx] = 1'b1;
          w_hs                 = 1'b1;
          w_state_nxt          = CMD;
        end
      end
      CMD:     w_state_nxt = CAPT;
      CAPT:    w_state_nxt = RSP;
      RSP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd        <= '0;
      r_owner      <= REQ_JTAG;
      r_rsp_rdata  <= '0;
      r_last_grant <= REQ_JTAG;
    end else begin
      if (w_hs) begin
        r_cmd   <= w_cmd;
        r_owner <= w_gnt_idx;
      end
      // DM read data is valid the cycle after the strobe, i.e. in CAPT.
      if (r_state == CAPT) begin
        r_rsp_rdata <= r_cmd.write ? 32'h0 : dmi_reg_rdata;
      end
      if (w_rsp) begin
        r_last_grant <= r_owner;
      end
    end
  end

  assign dmi_reg_en    = (r_state == CMD);
  assign dmi_reg_wr_en = dmi_reg_en & r_cmd.write;
  assign dmi_reg_addr  = AWIDTH'(r_cmd.addr);
  assign dmi_reg_wdata = r_cmd.wdata;
  assign rsp_valid     = w_rsp ? NUM_REQ'(idx_onehot(r_owner)) : '0;
  assign rsp_rdata     = r_rsp_rdata;
  assign busy          = (r_state != IDLE);
  assign last_grant    = r_last_grant;

endmodule

// File: tb/tb_css_mcu0_dmi_arbiter.sv
// Scoreboard bench for css_mcu0_dmi_arbiter with a small DM register model.
module tb_css_mcu0_dmi_arbiter;

  localparam int AW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [13:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, dmi_reg_wdata, dmi_reg_rdata;
  logic        dmi_reg_en, dmi_reg_wr_en, busy, last_grant;
  logic [6:0]  dmi_reg_addr;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  logic [1:0]  req_lock;
  logic [1:0]  lock_hold;
  bit          rnd_lock;
`endif

  typedef struct { bit write; bit [6:0] addr; bit [31:0] wdata; } cmd_t;
  typedef struct { int cyc; bit write; bit [6:0] addr; bit [31:0] wdata; } dmi_exp_t;
  typedef struct { int cyc; int idx; bit [31:0] data; } rsp_exp_t;

  cmd_t      cmdq [2][$];
  dmi_exp_t  eq_dmi[$];
  rsp_exp_t  eq_rsp[$];
  int        act_order[$];

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  int        m_free = 0, m_prio = 0, m_last = 0, m_owner = 0, m_rsp_cyc = -1;
  bit        m_locked = 1'b0;
  int        m_lock_owner = 0;
  bit [31:0] mem [128];
  bit [31:0] ref_mem [128];
  logic [31:0] dm_rdata;
  bit        hs_seen [2];
  bit        rnd_drop;

  css_mcu0_dmi_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .dmi_reg_en    (dmi_reg_en),
    .dmi_reg_wr_en (dmi_reg_wr_en),
    .dmi_reg_addr  (dmi_reg_addr),
    .dmi_reg_wdata (dmi_reg_wdata),
    .dmi_reg_rdata (dmi_reg_rdata),
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    .req_lock      (req_lock),
`endif
    .busy          (busy),
    .last_grant    (last_grant)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DM register file: read data appears the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (dmi_reg_en === 1'b1) begin
      if (dmi_reg_wr_en) mem[dmi_reg_addr] <= dmi_reg_wdata;
      dm_rdata <= mem[dmi_reg_addr];
    end else begin
      dm_rdata <= $urandom;
    end
  end
  assign dmi_reg_rdata = dm_rdata;

  // Driver: present queue heads, retire them once a handshake was observed.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs_seen[i] && cmdq[i].size() > 0) void'(cmdq[i].pop_front());
      hs_seen[i] = 1'b0;
      if (cmdq[i].size() > 0 && !(rnd_drop && $urandom_range(0, 3) == 0)) begin
        req_valid[i]           = 1'b1;
        req_write[i]           = cmdq[i][0].write;
        req_addr[i*AW +: AW]   = cmdq[i][0].addr;
        req_wdata[i*32 +: 32]  = cmdq[i][0].wdata;
      end else begin
        req_valid[i]           = 1'b0;
        req_write[i]           = 1'($urandom);
        req_addr[i*AW +: AW]   = 7'($urandom);
      end
    end
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    for (int i = 0; i < 2; i++) req_lock[i] = rnd_lock ? 1'($urandom) : lock_hold[i];
`endif
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
        hs_seen[i] = 1'b1;
        act_order.push_back(i);
      end
    end
  end

  // Reference model: one command in flight, 4-cycle occupancy, tie goes to the
  // requester not served last; responses predicted from a mirror of the DM.
  logic [1:0] m_cand, m_rdy;
  int         m_w;
  bit [6:0]   m_a;
  always @(negedge clk) begin
    m_rdy = 2'b00;
    if (rst) begin
      chk("busy", busy, cyc < m_free);
      chk("req_ready_in_reset", req_ready, 0);
      while (eq_dmi.size() > 0 && eq_dmi[$].cyc > cyc) void'(eq_dmi.pop_back());
      while (eq_rsp.size() > 0 && eq_rsp[$].cyc > cyc) void'(eq_rsp.pop_back());
      m_free = cyc + 1; m_prio = 0; m_last = 0; m_rsp_cyc = -1; m_locked = 1'b0;
    end else begin
      chk("last_grant", last_grant, m_last);
      chk("busy", busy, cyc < m_free);
      if (cyc == m_rsp_cyc) begin
        m_last = m_owner;
        m_prio = 1 - m_owner;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
        m_locked = req_lock[m_owner];
        m_lock_owner = m_owner;
`endif
      end
      if (cyc >= m_free) begin
        m_cand = req_valid;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
        if (m_locked) begin
          if (req_lock[m_lock_owner]) m_cand[1-m_lock_owner] = 1'b0;
          else m_locked = 1'b0;
        end
`endif
        m_w = (m_cand == 2'b11) ? m_prio : m_cand[0] ? 0 : m_cand[1] ? 1 : -1;
        if (m_w >= 0) begin
          m_rdy[m_w] = 1'b1;
          m_a = req_addr[m_w*AW +: AW];
          eq_dmi.push_back('{cyc + 1, req_write[m_w], m_a, req_wdata[m_w*32 +: 32]});
          if (req_write[m_w]) begin
            ref_mem[m_a] = req_wdata[m_w*32 +: 32];
            eq_rsp.push_back('{cyc + 3, m_w, 32'h0});
          end else begin
            eq_rsp.push_back('{cyc + 3, m_w, ref_mem[m_a]});
          end
          m_free = cyc + 4; m_rsp_cyc = cyc + 3; m_owner = m_w;
        end
      end
      chk("req_ready", req_ready, m_rdy);
    end
  end

  // Monitor: compare DM strobes and responses against the scoreboard.
  dmi_exp_t de;
  rsp_exp_t re;
  always @(negedge clk) begin
    while (eq_dmi.size() > 0 && eq_dmi[0].cyc < cyc) begin
      chk("dmi_en_missing", 0, 1); void'(eq_dmi.pop_front());
    end
    if (dmi_reg_en === 1'b1) begin
      if (eq_dmi.size() > 0 && eq_dmi[0].cyc == cyc) begin
        de = eq_dmi.pop_front();
        chk("dmi_wr_en", dmi_reg_wr_en, de.write);
        chk("dmi_addr", dmi_reg_addr, de.addr);
        if (de.write) chk("dmi_wdata", dmi_reg_wdata, de.wdata);
      end else chk("dmi_en_unexpected", 1, 0);
    end else if (eq_dmi.size() > 0 && eq_dmi[0].cyc == cyc) begin
      chk("dmi_en_missing", 0, 1); void'(eq_dmi.pop_front());
    end
    while (eq_rsp.size() > 0 && eq_rsp[0].cyc < cyc) begin
      chk("rsp_missing", 0, 1); void'(eq_rsp.pop_front());
    end
    if (rsp_valid !== 2'b00) begin
      if (eq_rsp.size() > 0 && eq_rsp[0].cyc == cyc) begin
        re = eq_rsp.pop_front();
        chk("rsp_valid_owner", rsp_valid, (re.idx == 1) ? 2'b10 : 2'b01);
        chk("rsp_rdata", rsp_rdata, re.data);
      end else chk("rsp_unexpected", rsp_valid, 0);
    end else if (eq_rsp.size() > 0 && eq_rsp[0].cyc == cyc) begin
      chk("rsp_missing", 0, 1); void'(eq_rsp.pop_front());
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = cmdq[0].size() == 0 && cmdq[1].size() == 0 && eq_dmi.size() == 0 &&
             eq_rsp.size() == 0 && cyc >= m_free;
    end
    chk(name, done, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmi_en"}, dmi_reg_en, 0);
    chk({tag, "_dmi_wr_en"}, dmi_reg_wr_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last_grant"}, last_grant, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin : main
    int n;
    int cnt;
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rnd_drop = 1'b0;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    lock_hold = '0; rnd_lock = 1'b0; req_lock = '0;
`endif
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[7'h11] = 32'h0000_0C82; ref_mem[7'h11] = 32'h0000_0C82;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_dmi_addr", dmi_reg_addr, 0);
    chk("reset_dmi_wdata", dmi_reg_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // SW read of 0x11, then JTAG write 0x10.
    cmdq[1].push_back('{1'b0, 7'h11, 32'h0});
    wait_done("single_read_done", 50);
    @(posedge clk); #1;
    cmdq[0].push_back('{1'b1, 7'h10, 32'h8000_0001});
    wait_done("single_write_done", 50);

    // Both requesters valid from reset: strict alternation.
    @(posedge clk); #1 rst = 1'b1;
    act_order.delete();
    for (int k = 0; k < 4; k++) begin
      cmdq[0].push_back('{1'(k), 7'(8'h20 + k), 32'hA000_0000 + k});
      cmdq[1].push_back('{1'(k + 1), 7'(8'h30 + k), 32'hB000_0000 + k});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_done("contention_done", 100);
    chk("contention_count", act_order.size(), 8);
    for (int k = 0; k < act_order.size() && k < 8; k++) chk("contention_order", act_order[k], k % 2);

    // Random traffic with legal valid drops.
    @(posedge clk); #1;
    rnd_drop = 1'b1;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    rnd_lock = 1'b1;
`endif
    for (int k = 0; k < 40; k++)
      cmdq[$urandom_range(0, 1)].push_back('{1'($urandom), 7'($urandom), $urandom});
    wait_done("random_done", 4000);
    rnd_drop = 1'b0;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    rnd_lock = 1'b0; lock_hold = '0;
`endif

    // Reset while in CAPT aborts the SW read.
    @(posedge clk); #1;
    n = act_order.size();
    cmdq[1].push_back('{1'b0, 7'h22, 32'h0});
    cnt = 0;
    while (act_order.size() == n && cnt < 50) begin @(negedge clk); cnt++; end
    chk("midrst_handshake", act_order.size() > n, 1);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk); #1;
    cmdq[1].push_back('{1'b0, 7'h11, 32'h0});
    wait_done("post_reset_read_done", 50);

`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    // JTAG holds the bus for three reads while SW waits.
    @(posedge clk); #1 rst = 1'b1;
    lock_hold[0] = 1'b1;
    act_order.delete();
    for (int k = 0; k < 3; k++) cmdq[0].push_back('{1'b0, 7'(8'h40 + k), 32'h0});
    cmdq[1].push_back('{1'b0, 7'h50, 32'h0});
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    while (cmdq[0].size() != 0 && cnt < 100) begin @(posedge clk); #2; cnt++; end
    lock_hold[0] = 1'b0;
    wait_done("lock_done", 100);
    chk("lock_count", act_order.size(), 4);
    for (int k = 0; k < act_order.size() && k < 4; k++) chk("lock_order", act_order[k], (k == 3) ? 1 : 0);
`endif

    // Idle stability.
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (dmi_reg_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 2'b00) cnt++;
    end
    chk("idle_quiet", cnt, 0);
    chk("final_dmi_queue_empty", eq_dmi.size(), 0);
    chk("final_rsp_queue_empty", eq_rsp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
